buffer_memwb_param: RTL and testbench

Parametrised MEM/WB pipeline register for the processor datapath, between the data-memory stage and the register-file write port. It carries the ALU result, the load data, the destination register and the control bits through a configurable number of register stages. Beyond a plain pipeline register it adds:
- a per-slot valid bit, with stall (hold) and flush (bubble insertion);
- a registered write-back mux;
- a forwarding tap;
- a retired-instruction counter.

---
 rtl/buffer_memwb_param.sv | 135 +++++++++++++
 tb/tb_buffer_memwb_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_memwb_param.sv
// MEM/WB pipeline register with DEPTH stages, per-slot valid, stall/flush, registered
// write-back mux, forwarding qualifier and a retired-instruction counter.
module buffer_memwb_param #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic          regwrite,
  input  logic          memtoreg,
  input  logic          flag,
  input  logic [DW-1:0] res,
  input  logic [DW-1:0] dato,
  input  logic [RW-1:0] AW,
  output logic          out_valid,
  output logic          out_regwrite,
  output logic          out_memtoreg,
  output logic          out_flag,
  output logic [DW-1:0] res_out,
  output logic [DW-1:0] salida,
  output logic [DW-1:0] dato_out,
  output logic [RW-1:0] out_AW,
  output logic [DW-1:0] wb_data,
  output logic          fwd_en,
  output logic [CW-1:0] retired
);

  if (DEPTH < 1 || DEPTH > 3) begin : g_depth_chk
    $error("buffer_memwb_param: DEPTH must be in 1..3");
  end

  localparam int unsigned Last = DEPTH - 1;

  logic          valid_q    [DEPTH];
  logic          valid_d    [DEPTH];
  logic          regwrite_q [DEPTH];
  logic          regwrite_d [DEPTH];
  logic          memtoreg_q [DEPTH];
  logic          memtoreg_d [DEPTH];
  logic          flag_q     [DEPTH];
  logic          flag_d     [DEPTH];
  logic [DW-1:0] res_q      [DEPTH];
  logic [DW-1:0] res_d      [DEPTH];
  logic [DW-1:0] dato_q     [DEPTH];
  logic [DW-1:0] dato_d     [DEPTH];
  logic [RW-1:0] aw_q       [DEPTH];
  logic [RW-1:0] aw_d       [DEPTH];
  logic [DW-1:0] wb_q       [DEPTH];
  logic [DW-1:0] wb_d       [DEPTH];
  logic [CW-1:0] retired_q, retired_d;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    flag_d     = flag_q;
    res_d      = res_q;
    dato_d     = dato_q;
    aw_d       = aw_q;
    wb_d       = wb_q;
    retired_d  = retired_q;

    if (!stall) begin
      valid_d[0]    = in_valid & ~flush;
      regwrite_d[0] = regwrite;
      memtoreg_d[0] = memtoreg;
      flag_d[0]     = flag;
      res_d[0]      = res;
      dato_d[0]     = dato;
      aw_d[0]       = AW;
      // Write-back select is resolved at capture so wb_data leaves a flop.
      wb_d[0]       = memtoreg ? dato : res;
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_d[k]    = valid_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        memtoreg_d[k] = memtoreg_q[k-1];
        flag_d[k]     = flag_q[k-1];
        res_d[k]      = res_q[k-1];
        dato_d[k]     = dato_q[k-1];
        aw_d[k]       = aw_q[k-1];
        wb_d[k]       = wb_q[k-1];
      end
      if (valid_q[Last]) begin
        retired_d = retired_q + CW'(1);
      end
    end else if (flush) begin
      // Stalled flush empties slot 0 in place; everything else holds.
      valid_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        valid_q[k]    <= 1'b0;
        regwrite_q[k] <= 1'b0;
        memtoreg_q[k] <= 1'b0;
        flag_q[k]     <= 1'b0;
        res_q[k]      <= '0;
        dato_q[k]     <= '0;
        aw_q[k]       <= '0;
        wb_q[k]       <= '0;
      end
      retired_q <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      flag_q     <= flag_d;
      res_q      <= res_d;
      dato_q     <= dato_d;
      aw_q       <= aw_d;
      wb_q       <= wb_d;
      retired_q  <= retired_d;
    end
  end

  assign out_valid    = valid_q[Last];
  assign out_regwrite = regwrite_q[Last] & valid_q[Last];
  assign out_memtoreg = memtoreg_q[Last];
  assign out_flag     = flag_q[Last];
  assign res_out      = res_q[Last];
  assign salida       = res_q[Last];
  assign dato_out     = dato_q[Last];
  assign out_AW       = aw_q[Last];
  assign wb_data      = wb_q[Last];
  assign fwd_en       = out_regwrite & (aw_q[Last] != '0);
  assign retired      = retired_q;

endmodule

// File: tb/tb_buffer_memwb_param.sv
// Scoreboard bench: three instances (DEPTH 1..3, CW=4) share one randomized stimulus stream.
module tb_buffer_memwb_param;

  typedef struct {
    logic        regwrite;
    logic        memtoreg;
    logic        flag;
    logic [31:0] res;
    logic [31:0] dato;
    logic [4:0]  aw;
    int          e;
    int          s;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, regwrite, memtoreg, flag;
  logic [31:0] res, dato;
  logic [4:0]  aw;

  logic        ov   [3];
  logic        orw  [3];
  logic        omtr [3];
  logic        ofl  [3];
  logic [31:0] ores [3];
  logic [31:0] osal [3];
  logic [31:0] odat [3];
  logic [4:0]  oaw  [3];
  logic [31:0] owb  [3];
  logic        ofwd [3];
  logic [3:0]  oret [3];

  rec_t        exp_q [3][$];
  logic [3:0]  ret_m [3];
  logic        live;
  int          edge_cnt, stall_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    buffer_memwb_param #(
      .DW   (32),
      .RW   (5),
      .DEPTH(g + 1),
      .CW   (4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .stall       (stall),
      .flush       (flush),
      .regwrite    (regwrite),
      .memtoreg    (memtoreg),
      .flag        (flag),
      .res         (res),
      .dato        (dato),
      .AW          (aw),
      .out_valid   (ov[g]),
      .out_regwrite(orw[g]),
      .out_memtoreg(omtr[g]),
      .out_flag    (ofl[g]),
      .res_out     (ores[g]),
      .salida      (osal[g]),
      .dato_out    (odat[g]),
      .out_AW      (oaw[g]),
      .wb_data     (owb[g]),
      .fwd_en      (ofwd[g]),
      .retired     (oret[g])
    );
  end

  function automatic string nm(string s, int g);
    return $sformatf("%s[depth%0d]", s, g + 1);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic chk_zero(int g);
    chk(nm("rst_valid", g), ov[g], 0);
    chk(nm("rst_regwrite", g), orw[g], 0);
    chk(nm("rst_memtoreg", g), omtr[g], 0);
    chk(nm("rst_flag", g), ofl[g], 0);
    chk(nm("rst_res", g), ores[g], 0);
    chk(nm("rst_salida", g), osal[g], 0);
    chk(nm("rst_dato", g), odat[g], 0);
    chk(nm("rst_aw", g), oaw[g], 0);
    chk(nm("rst_wb", g), owb[g], 0);
    chk(nm("rst_fwd", g), ofwd[g], 0);
    chk(nm("rst_retired", g), oret[g], 0);
  endtask

  // Reference: which instructions get accepted, and which get killed while sitting in slot 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        exp_q[g].delete();
        ret_m[g] = 4'd0;
      end
      live      = 1'b0;
      edge_cnt  = 0;
      stall_cnt = 0;
    end else begin
      edge_cnt++;
      if (stall) stall_cnt++;
      if (!stall) begin
        live = in_valid && !flush;
        if (live) begin
          for (int g = 0; g < 3; g++)
            exp_q[g].push_back('{regwrite, memtoreg, flag, res, dato, aw, edge_cnt, stall_cnt});
        end
      end else if (flush && live) begin
        for (int g = 0; g < 3; g++)
          if (exp_q[g].size() > 0) void'(exp_q[g].pop_back());
        live = 1'b0;
      end
    end
  end

  // Monitor: compare the presented slot against the oldest outstanding instruction.
  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        chk(nm("retired", g), oret[g], ret_m[g]);
        if (ov[g]) begin
          if (exp_q[g].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got out_valid=1 expected no instruction", nm("spurious", g));
          end else begin
            r = exp_q[g][0];
            chk(nm("res_out", g), ores[g], r.res);
            chk(nm("salida", g), osal[g], r.res);
            chk(nm("dato_out", g), odat[g], r.dato);
            chk(nm("out_AW", g), oaw[g], r.aw);
            chk(nm("out_memtoreg", g), omtr[g], r.memtoreg);
            chk(nm("out_flag", g), ofl[g], r.flag);
            chk(nm("out_regwrite", g), orw[g], r.regwrite);
            chk(nm("wb_data", g), owb[g], r.memtoreg ? r.dato : r.res);
            chk(nm("fwd_en", g), ofwd[g], r.regwrite && (r.aw != 5'd0));
            if (!stall) begin
              chk(nm("latency", g), (edge_cnt - r.e) - (stall_cnt - r.s), g);
              void'(exp_q[g].pop_front());
              ret_m[g] = ret_m[g] + 4'd1;
            end
          end
        end else begin
          chk(nm("idle_regwrite", g), orw[g], 0);
          chk(nm("idle_fwd", g), ofwd[g], 0);
        end
      end
    end
  end

  task automatic drive(logic v, logic st, logic fl, logic rw, logic mtr, logic fg,
                       logic [31:0] r, logic [31:0] d, logic [4:0] a);
    in_valid = v;
    stall    = st;
    flush    = fl;
    regwrite = rw;
    memtoreg = mtr;
    flag     = fg;
    res      = r;
    dato     = d;
    aw       = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; stall = 0; flush = 0; regwrite = 0; memtoreg = 0; flag = 0;
    res = '0; dato = '0; aw = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk_zero(g);
    rst = 1'b0;

    // Pass-through on the single-stage instance.
    drive(1, 0, 0, 1, 1, 0, 32'h0000_00AA, 32'h1234_5678, 5'd7);
    chk("pt_res_out", ores[0], 32'hAA);
    chk("pt_salida", osal[0], 32'hAA);
    chk("pt_dato_out", odat[0], 32'h1234_5678);
    chk("pt_wb_data", owb[0], 32'h1234_5678);
    chk("pt_out_AW", oaw[0], 7);
    chk("pt_out_regwrite", orw[0], 1);
    chk("pt_fwd_en", ofwd[0], 1);

    // Writes to register 0 must not forward.
    drive(1, 0, 0, 1, 0, 0, 32'h55, 32'h66, 5'd0);
    chk("x0_out_regwrite", orw[0], 1);
    chk("x0_fwd_en", ofwd[0], 0);
    chk("x0_wb_data", owb[0], 32'h55);

    // Flushed instruction leaves as a bubble.
    drive(1, 0, 1, 1, 0, 0, 32'h77, 32'h88, 5'd9);
    chk("fl_out_valid", ov[0], 0);
    chk("fl_out_regwrite", orw[0], 0);
    chk("fl_fwd_en", ofwd[0], 0);
    repeat (3) idle();

    // Stalled flush: slot 0 emptied, downstream slots keep their contents.
    drive(1, 0, 0, 1, 0, 1, 32'h101, 32'h0, 5'd3);
    drive(1, 0, 0, 1, 0, 0, 32'h102, 32'h0, 5'd4);
    drive(1, 1, 1, 1, 0, 0, 32'h103, 32'h0, 5'd5);
    chk("sf_d3_res_hold", ores[2], 32'h0);
    chk("sf_d2_res_hold", ores[1], 32'h101);
    repeat (4) idle();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
    end

    // Mid-stream asynchronous reset with instructions in flight.
    drive(1, 0, 0, 1, 1, 1, 32'hAAAA_0001, 32'hBBBB_0001, 5'd11);
    drive(1, 0, 0, 1, 0, 1, 32'hAAAA_0002, 32'hBBBB_0002, 5'd12);
    #1;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk_zero(g);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0, 32'hCAFE_0001, 32'h0, 5'd13);
    repeat (5) idle();

    for (int g = 0; g < 3; g++) chk(nm("drained", g), exp_q[g].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
